// File: rtl/iic_arbiter.sv
// rtl/iic_arbiter.sv - round-robin arbiter sharing one iic_driver between two requesters
// Grants per burst, forwards one byte at a time and releases the bus if the driver hangs.
module iic_arbiter #(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       start0_i,
    input  logic       start1_i,
    input  logic       dc0_i,
    input  logic       dc1_i,
    input  logic [7:0] data0_i,
    input  logic [7:0] data1_i,
    output logic       gnt0_o,
    output logic       gnt1_o,
    output logic       done0_o,
    output logic       done1_o,
    output logic       iic_start_o,
    output logic       iic_dc_o,
    output logic [7:0] iic_data_o,
    input  logic       iic_done_i,
    output logic       timeout_o
);

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            gnt0_q, gnt0_d;
    logic            gnt1_q, gnt1_d;
    logic            done0_q, done0_d;
    logic            done1_q, done1_d;
    logic            iic_start_q, iic_start_d;
    logic            iic_dc_q, iic_dc_d;
    logic [7:0]      iic_data_q, iic_data_d;
    logic            timeout_q, timeout_d;

    logic            own_req;
    logic            own_start;
    logic            own_dc;
    logic [7:0]      own_data;
    logic            grant;
    logic            grant_id;

    always_comb begin
        own_req   = owner_q ? req1_i   : req0_i;
        own_start = owner_q ? start1_i : start0_i;
        own_dc    = owner_q ? dc1_i    : dc0_i;
        own_data  = owner_q ? data1_i  : data0_i;
    end

    // The requester that did not win last time takes a tie.
    always_comb begin
        grant    = 1'b0;
        grant_id = 1'b0;
        if (req0_i && req1_i) begin
            grant    = 1'b1;
            grant_id = ~last_q;
        end else if (req0_i) begin
            grant    = 1'b1;
            grant_id = 1'b0;
        end else if (req1_i) begin
            grant    = 1'b1;
            grant_id = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        wd_d        = wd_q;
        gnt0_d      = gnt0_q;
        gnt1_d      = gnt1_q;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        iic_start_d = 1'b0;
        iic_dc_d    = iic_dc_q;
        iic_data_d  = iic_data_q;
        timeout_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    owner_d = grant_id;
                    last_d  = grant_id;
                    gnt0_d  = ~grant_id;
                    gnt1_d  = grant_id;
                    state_d = S_OWN;
                end
            end
            S_OWN: begin
                if (own_start) begin
                    iic_dc_d    = own_dc;
                    iic_data_d  = own_data;
                    iic_start_d = 1'b1;
                    wd_d        = '0;
                    state_d     = S_XFER;
                end else if (!own_req) begin
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_XFER: begin
                // A completion on the threshold cycle still wins over the watchdog.
                if (iic_done_i) begin
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    state_d = S_OWN;
                end else if (wd_q == WD_MAX) begin
                    timeout_d = 1'b1;
                    gnt0_d    = 1'b0;
                    gnt1_d    = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            wd_q        <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            iic_start_q <= 1'b0;
            iic_dc_q    <= 1'b0;
            iic_data_q  <= 8'h00;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            wd_q        <= wd_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            iic_start_q <= iic_start_d;
            iic_dc_q    <= iic_dc_d;
            iic_data_q  <= iic_data_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt0_o      = gnt0_q;
    assign gnt1_o      = gnt1_q;
    assign done0_o     = done0_q;
    assign done1_o     = done1_q;
    assign iic_start_o = iic_start_q;
    assign iic_dc_o    = iic_dc_q;
    assign iic_data_o  = iic_data_q;
    assign timeout_o   = timeout_q;

endmodule

// File: doc/iic_arbiter.md
# iic_arbiter

Two-requester arbiter that shares the single `iic_driver` instance between the OLED sequencer (`data_ctrl`) and a second I2C client, such as a sensor poller. It sits between the requesters and `iic_driver`. It grants the bus on a per-burst basis, forwards one byte transaction (dc + 8-bit data) at a time, and routes `iic_done` back to the owner. Ties are resolved round-robin, and a watchdog releases the bus if the driver hangs.

## Interface
- `TIMEOUT_CYCLES`, default 200000: maximum cycles a byte may stay in flight before the bus is forcibly released. Must be ≥ 2.
- `clk`  in  1: system clock.
- `rst`  in  1: reset, synchronous and active-high.
- `req0`, `req1`  in  1: bus request. Held high for the whole burst; dropping it ends the burst.
- `start0`, `start1`  in  1: one-cycle byte-start pulse from each requester.
- `dc0`, `dc1`  in  1: command/data select for the byte, sampled with `startN`.
- `data0`, `data1`  in  8: byte payload, sampled with `startN`.
- `gnt0`, `gnt1`  out  1: grant. At most one is high.
- `done0`, `done1`  out  1: one-cycle pulse when the owner's byte completes.
- `iic_start`  out  1: one-cycle start pulse to `iic_driver`.
- `iic_dc`  out  1: registered dc to `iic_driver`.
- `iic_data`  out  8: registered byte to `iic_driver`.
- `iic_done`  in  1: completion pulse from `iic_driver`.
- `timeout`  out  1: one-cycle pulse when the watchdog fires.

## Operation
- **States:** IDLE, OWN, XFER. The owner is held in a 1-bit `owner` register. Round-robin history is held in a 1-bit `last` register.
- **IDLE:**
  - Only one `reqN` high: grant N.
  - Both high: grant the requester that is not `last`.
  - Neither high: stay in IDLE.
  - On grant: `owner`=N, `last`=N, go to OWN.
- **OWN:**
  - `start[owner]`=1: latch `dc[owner]` and `data[owner]` into `iic_dc`/`iic_data`, pulse `iic_start`, clear the watchdog, go to XFER.
  - Otherwise, if `req[owner]`=0: drop the grant and go to IDLE.
  - `start` takes priority over a same-cycle `req` drop.
- **XFER:**
  - `iic_done`=1: pulse `done[owner]` and return to OWN.
  - Otherwise the watchdog increments. When it reaches `TIMEOUT_CYCLES-1`, pulse `timeout`, drop the grant and go to IDLE. No `done` pulse is issued in that case.
  - `iic_done` in the same cycle as the watchdog threshold counts as done; `timeout` is not pulsed.
- **Ignored inputs:**
  - `startN` from a non-owner, in any state.
  - `start` from the owner while in XFER.
  - `iic_done` outside XFER.
  - `req` changes during XFER, until the byte completes.
- `iic_dc` and `iic_data` stay stable from `iic_start` until the next accepted start or reset.
- The watchdog counter is `$clog2(TIMEOUT_CYCLES)` bits wide, saturates at its threshold, and resets to 0 on entry to XFER.

## Timing
- **Reset values:** all outputs 0 (`gnt*`, `done*`, `iic_start`, `iic_dc`, `iic_data`=8'h00, `timeout`); state IDLE; `last`=1, so `req0` wins the first tie; watchdog 0.
- Reset asserted mid-XFER forces these values on the next edge. `iic_driver` shares `rst` and aborts with it.
- **All outputs are registered.**
  - `req` high at cycle t in IDLE → `gnt` high at t+1.
  - Accepted `start` at t → `iic_start`, `iic_dc`, `iic_data` valid at t+1.
  - `iic_done` at t → `done[owner]` at t+1. The owner may issue the next `start` at t+1, which is accepted (state is OWN).
- **Release:**
  - `req` drop at t in OWN → `gnt` low at t+1.
  - Earliest new grant is at t+2, because IDLE spends one cycle arbitrating.
- **Burst throughput:** back-to-back bytes add 1 arbiter cycle of overhead per byte, on top of `iic_driver` latency.
- **Timeout:** XFER entered at cycle e with no `iic_done` → `timeout` and `gnt` low at e+`TIMEOUT_CYCLES`.

## Test plan
- **Single requester burst:** `req0`=1, three starts with data 8'hAE, 8'h00, 8'hFF and `dc0`=0,0,1; driver model returns `iic_done` 10 cycles after each `iic_start`. Expect 3 `iic_start` pulses with matching `iic_data`/`iic_dc`, 3 `done0` pulses, `gnt1` never high, and `done1` never high.
- **Simultaneous requests after reset:** `req0`=`req1`=1 at the same cycle. Expect `gnt0` first. When `req0` drops, expect `gnt1` exactly 2 cycles later. Re-raise `req0` during requester 1's burst; after requester 1 releases, expect `gnt0`.
- **Fairness:** both requesters hold `req` and release after each single byte. Expect grants to alternate 0,1,0,1 over 8 bursts.
- **Non-owner and stray inputs:** while `gnt0`, pulse `start1` with 8'h55, pulse `iic_done` while in OWN, and drop `req0` during XFER. Expect no extra `iic_start`, no spurious `done`, and `gnt0` held until the pending `done0`.
- **Watchdog:** with `TIMEOUT_CYCLES`=16, start a byte and never return `iic_done`. Expect `timeout` pulse and `gnt0` low 16 cycles after `iic_start`, and no `done0`. A waiting `req1` is granted on the following cycle. Separately, return `iic_done` exactly on the threshold cycle: expect `done0` and no `timeout`.
- **Reset mid-transfer:** assert `rst` for 1 cycle during XFER. Expect all outputs 0 on the next edge and state IDLE. With both requests high after reset, `gnt0` wins.
